sa_rr_lock_arbiter: RTL and testbench

- Parameterised N-input output-port arbiter for the switch allocator.
- Shares one output channel between N input requesters using a rotating (round-robin) priority pointer.
- Once the first beat of a multi-beat packet is accepted, the grant is locked to that requester until its tail beat transfers (wormhole hold).
- Generalises the fixed 2x2 token allocator to N inputs with packet-level locking and downstream backpressure.

---
 rtl/sa_rr_lock_arbiter.sv | 176 +++++++++++++++++
 tb/tb_sa_rr_lock_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_rr_lock_arbiter.sv
// sa_rr_lock_arbiter
// -----------------------------------------------------------------------------
// N-input output-port arbiter for the switch allocator. One output channel is
// shared between N requesters using a rotating priority pointer. When the first
// beat of a multi-beat packet is accepted, the grant is locked to that requester
// until its tail beat transfers (wormhole hold).
//
// Optional build macro: SA_HOLD_TIMEOUT_EN
//   When defined, a locked owner that leaves its request low for MAX_HOLD
//   consecutive cycles is forcibly released. A one-cycle pulse on 'timeout'
//   marks the release. When undefined, 'timeout' is tied low and a lock lasts
//   until a tail transfer or reset.
//
// Handshake: a beat transfers in any cycle where gnt_valid and ready are both
// high. gnt/gnt_id/gnt_valid are combinational from req and the registered
// state; ready never affects the grant, only whether it is consumed.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   req[N]     bit i high: requester i has a beat to send
//   tail[N]    bit i high: requester i's current beat ends its packet
//   ready      downstream accepts a beat this cycle
//   gnt[N]     one-hot grant, or all zero
//   gnt_id     binary index of the granted requester (0 when gnt_valid=0)
//   gnt_valid  high when gnt is non-zero
//   busy       high while locked to a packet owner (exposes the FSM state)
//   timeout    one-cycle forced-release pulse (0 without SA_HOLD_TIMEOUT_EN)
// -----------------------------------------------------------------------------
module sa_rr_lock_arbiter #(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 16,
    localparam int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   tail,
    input  logic           ready,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid,
    output logic           busy,
    output logic           timeout
);

    if (N < 2 || MAX_HOLD < 1) begin : g_bad_params
        $error("sa_rr_lock_arbiter: requires N >= 2 and MAX_HOLD >= 1");
    end

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] owner_q, owner_d;

    logic [IDW-1:0] win_id;
    logic           win_found;
    logic [IDW-1:0] sel_id;
    logic           sel_valid;
    logic           xfer;
    logic           force_rel;

    // Index after i, wrapping N-1 back to 0 (N need not be a power of two).
    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
        return (i == IDW'(N - 1)) ? '0 : i + 1'b1;
    endfunction

    // Round-robin search starting at ptr_q.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = int'(ptr_q) + k;
            if (j >= N) j = j - N;
            if (!win_found && req[IDW'(j)]) begin
                win_found = 1'b1;
                win_id    = IDW'(j);
            end
        end
    end

    // While locked only the owner may be granted. The rst_n term keeps all
    // grant outputs low during reset even though req is still being driven.
    always_comb begin
        sel_id    = win_id;
        sel_valid = win_found;
        if (state_q == LOCKED) begin
            sel_id    = owner_q;
            sel_valid = req[owner_q];
        end
        sel_valid = sel_valid & rst_n;
    end

    assign gnt_valid = sel_valid;
    assign gnt_id    = sel_valid ? sel_id : '0;
    assign gnt       = sel_valid ? (N'(1) << sel_id) : '0;
    assign busy      = (state_q == LOCKED);
    assign xfer      = sel_valid & ready;

    // Next-state logic. tail is only looked at for the granted index.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        if (xfer) begin
            if (tail[sel_id]) begin
                state_d = IDLE;
                ptr_d   = next_idx(sel_id);
            end else if (state_q == IDLE) begin
                state_d = LOCKED;
                owner_d = sel_id;
            end
        end
        // force_rel only fires while req[owner] is low, so it never
        // coincides with a transfer.
        if (force_rel) begin
            state_d = IDLE;
            ptr_d   = next_idx(owner_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

`ifdef SA_HOLD_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          stall;

    assign stall = (state_q == LOCKED) && !req[owner_q];

    // The counter value before this cycle's stall is cnt_q, so the release
    // happens on the MAX_HOLD-th consecutive stall cycle. Any cycle with
    // the owner requesting, and every IDLE cycle, clears it.
    always_comb begin
        cnt_d     = '0;
        force_rel = 1'b0;
        if (stall) begin
            if (cnt_q == CW'(MAX_HOLD - 1)) begin
                force_rel = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = force_rel;
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_sa_rr_lock_arbiter.sv
// Directed testbench for sa_rr_lock_arbiter (N=4, MAX_HOLD=4).
// Observed vector per cycle: {gnt[3:0], gnt_id[1:0], gnt_valid, busy, timeout}.
module tb_sa_rr_lock_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] tail;
    logic       ready;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int fails  = 0;

    sa_rr_lock_arbiter #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .tail      (tail),
        .ready     (ready),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .busy      (busy),
        .timeout   (timeout)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        tail  = '0;
        ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- driver ----------------
    // Inputs change on the falling edge; outputs are sampled 1 time unit later,
    // well away from the rising edge that updates state.
    task automatic step(input logic [3:0] r, input logic [3:0] t, input logic rdy);
        @(negedge clk);
        req   = r;
        tail  = t;
        ready = rdy;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [8:0] obs;
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b1111;
        tail  = 4'b1111;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            obs = {gnt, gnt_id, gnt_valid, busy, timeout};
            checks++;
            if (obs !== 9'b0000_00_000) begin
                fails++;
                $display("FAIL reset_hold[%0d]: got %b, expected %b", i, obs, 9'b0000_00_000);
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
        #1;
        obs = {gnt, gnt_id, gnt_valid, busy, timeout};
        checks++;
        if (obs !== 9'b0001_00_100) begin
            fails++;
            $display("FAIL reset_release: got %b, expected %b", obs, 9'b0001_00_100);
        end
    endtask

    task automatic test_round_robin();
        logic [8:0] exp_t [5];
        logic [8:0] obs;
        exp_t = '{9'b0001_00_100, 9'b0010_01_100, 9'b0100_10_100,
                  9'b1000_11_100, 9'b0001_00_100};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 4'b1111, 1'b1);
            obs = {gnt, gnt_id, gnt_valid, busy, timeout};
            checks++;
            if (obs !== exp_t[i]) begin
                fails++;
                $display("FAIL round_robin[%0d]: got %b, expected %b", i, obs, exp_t[i]);
            end
        end
    endtask

    task automatic test_packet_lock();
        logic [3:0] r_t [4];
        logic [3:0] t_t [4];
        logic [8:0] exp_t [4];
        logic [8:0] obs;
        r_t   = '{4'b0011, 4'b0011, 4'b0011, 4'b0011};
        t_t   = '{4'b0010, 4'b0000, 4'b0001, 4'b0011};
        exp_t = '{9'b0001_00_100, 9'b0001_00_110, 9'b0001_00_110, 9'b0010_01_100};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(r_t[i], t_t[i], 1'b1);
            obs = {gnt, gnt_id, gnt_valid, busy, timeout};
            checks++;
            if (obs !== exp_t[i]) begin
                fails++;
                $display("FAIL packet_lock[%0d]: got %b, expected %b", i, obs, exp_t[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] r_t [6];
        logic [3:0] t_t [6];
        logic       y_t [6];
        logic [8:0] exp_t [6];
        logic [8:0] obs;
        r_t   = '{4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0111};
        t_t   = '{4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0100, 4'b0000};
        y_t   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_t = '{9'b0010_01_100, 9'b0010_01_100, 9'b0010_01_100,
                  9'b0010_01_100, 9'b0100_10_100, 9'b0100_10_100};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(r_t[i], t_t[i], y_t[i]);
            obs = {gnt, gnt_id, gnt_valid, busy, timeout};
            checks++;
            if (obs !== exp_t[i]) begin
                fails++;
                $display("FAIL backpressure[%0d]: got %b, expected %b", i, obs, exp_t[i]);
            end
        end
    endtask

    task automatic test_owner_bubble();
        logic [3:0] r_t [7];
        logic [3:0] t_t [7];
        logic       y_t [7];
        logic [8:0] exp_t [7];
        logic [8:0] obs;
        r_t   = '{4'b0100, 4'b1100, 4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b1100};
        t_t   = '{4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0100, 4'b1000, 4'b0000};
        y_t   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_t = '{9'b0100_10_100, 9'b0100_10_110, 9'b0000_00_010, 9'b0000_00_010,
                  9'b0100_10_110, 9'b1000_11_100, 9'b0100_10_100};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(r_t[i], t_t[i], y_t[i]);
            obs = {gnt, gnt_id, gnt_valid, busy, timeout};
            checks++;
            if (obs !== exp_t[i]) begin
                fails++;
                $display("FAIL owner_bubble[%0d]: got %b, expected %b", i, obs, exp_t[i]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [8:0] obs;
        do_reset();
        step(4'b1000, 4'b0000, 1'b1);
        obs = {gnt, gnt_id, gnt_valid, busy, timeout};
        checks++;
        if (obs !== 9'b1000_11_100) begin
            fails++;
            $display("FAIL midrst_first: got %b, expected %b", obs, 9'b1000_11_100);
        end
        step(4'b1000, 4'b0000, 1'b1);
        obs = {gnt, gnt_id, gnt_valid, busy, timeout};
        checks++;
        if (obs !== 9'b1000_11_110) begin
            fails++;
            $display("FAIL midrst_locked: got %b, expected %b", obs, 9'b1000_11_110);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        obs = {gnt, gnt_id, gnt_valid, busy, timeout};
        checks++;
        if (obs !== 9'b0000_00_000) begin
            fails++;
            $display("FAIL midrst_assert: got %b, expected %b", obs, 9'b0000_00_000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1000;
        tail  = 4'b1000;
        ready = 1'b1;
        #1;
        obs = {gnt, gnt_id, gnt_valid, busy, timeout};
        checks++;
        if (obs !== 9'b1000_11_100) begin
            fails++;
            $display("FAIL midrst_release: got %b, expected %b", obs, 9'b1000_11_100);
        end
        // Tail transfer by requester 3 wraps ptr to 0.
        step(4'b1001, 4'b1001, 1'b1);
        obs = {gnt, gnt_id, gnt_valid, busy, timeout};
        checks++;
        if (obs !== 9'b0001_00_100) begin
            fails++;
            $display("FAIL midrst_wrap: got %b, expected %b", obs, 9'b0001_00_100);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] r_t [5];
        logic [8:0] exp_t [5];
        logic [8:0] obs;
        r_t   = '{4'b0011, 4'b0011, 4'b0011, 4'b1011, 4'b1011};
        exp_t = '{9'b0001_00_100, 9'b0010_01_100, 9'b0001_00_100,
                  9'b0010_01_100, 9'b1000_11_100};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(r_t[i], r_t[i], 1'b1);
            obs = {gnt, gnt_id, gnt_valid, busy, timeout};
            checks++;
            if (obs !== exp_t[i]) begin
                fails++;
                $display("FAIL back_to_back[%0d]: got %b, expected %b", i, obs, exp_t[i]);
            end
        end
    endtask

    task automatic test_hold_timeout();
        logic [3:0] r_t [11];
        logic [3:0] t_t [11];
        logic       y_t [11];
        logic [8:0] exp_t [11];
        logic [8:0] obs;
`ifdef SA_HOLD_TIMEOUT_EN
        r_t   = '{4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0110, 4'b0100,
                  4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100};
        t_t   = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        y_t   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_t = '{9'b0010_01_100, 9'b0000_00_010, 9'b0000_00_010, 9'b0000_00_010,
                  9'b0010_01_110, 9'b0000_00_010, 9'b0000_00_010, 9'b0000_00_010,
                  9'b0000_00_011, 9'b0100_10_100, 9'b0100_10_100};
`else
        r_t   = '{4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0110, 4'b0100,
                  4'b0100, 4'b0100, 4'b0100, 4'b0110, 4'b0100};
        t_t   = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                  4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
        y_t   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_t = '{9'b0010_01_100, 9'b0000_00_010, 9'b0000_00_010, 9'b0000_00_010,
                  9'b0010_01_110, 9'b0000_00_010, 9'b0000_00_010, 9'b0000_00_010,
                  9'b0000_00_010, 9'b0010_01_110, 9'b0100_10_100};
`endif
        do_reset();
        for (int i = 0; i < 11; i++) begin
            step(r_t[i], t_t[i], y_t[i]);
            obs = {gnt, gnt_id, gnt_valid, busy, timeout};
            checks++;
            if (obs !== exp_t[i]) begin
                fails++;
                $display("FAIL hold_timeout[%0d]: got %b, expected %b", i, obs, exp_t[i]);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst_n = 1'b0;
        req   = '0;
        tail  = '0;
        ready = 1'b0;
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_owner_bubble();
        test_reset_mid_packet();
        test_back_to_back();
        test_hold_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
